// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, FSM state encodings and the address match helper.
// Used by both the bus target and the bus master.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        ADDR      = ST_ADDR,
        ADDR_ACK  = ST_ADDR_ACK,
        WRITE     = ST_WRITE,
        WRITE_ACK = ST_WRITE_ACK,
        READ      = ST_READ,
        READ_ACK  = ST_READ_ACK
    } i2c_state_t;

    // The address byte carries the 7-bit address in [7:1] and R/W in bit 0.
    function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                        input logic [I2C_ADDR_W-1:0] addr);
        return addr_byte[I2C_BYTE_W-1:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA to clk and derives SCL edge and START/STOP strobes.
// Strobes are decoded from the last sync stage and a registered previous value.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_prev;
    logic                   sda_prev;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Flops come out of reset at the idle bus level so no spurious edge is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    // START/STOP require SCL high on both samples so an SCL edge never aliases.
    assign sda_level = sda_s;
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start     = scl_s & scl_prev & ~sda_s & sda_prev;
    assign stop      = scl_s & scl_prev & sda_s & ~sda_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: fixed 7-bit address, ACKs every written byte, returns tx_data on reads.
// SDA is open-drain; the target never stretches SCL.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_load,
    output logic                  selected,
    output logic                  rw
);

    logic sda_in;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .sda_level(sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_t            state,     state_nxt;
    logic [2:0]            bit_cnt,   bit_cnt_nxt;
    logic [I2C_BYTE_W-1:0] shift_reg, shift_nxt;
    logic                  sda_low,   sda_low_nxt;
    logic                  ack_phase, ack_phase_nxt;
    logic                  selected_nxt;
    logic                  rw_nxt;
    logic [I2C_BYTE_W-1:0] rx_data_nxt;
    logic                  rx_valid_nxt;
    logic                  tx_load_nxt;
    logic [I2C_BYTE_W-1:0] shift_in;

    assign shift_in = {shift_reg[I2C_BYTE_W-2:0], sda_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sda_low   <= 1'b0;
            ack_phase <= 1'b0;
            selected  <= 1'b0;
            rw        <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            sda_low   <= sda_low_nxt;
            ack_phase <= ack_phase_nxt;
            selected  <= selected_nxt;
            rw        <= rw_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_load   <= tx_load_nxt;
        end
    end

    // ack_phase: in the ACK states it marks that the ACK low is already on the bus;
    // in READ_ACK it records that the master acknowledged the byte.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        sda_low_nxt   = sda_low;
        ack_phase_nxt = ack_phase;
        selected_nxt  = selected;
        rw_nxt        = rw;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_load_nxt   = 1'b0;

        if (start) begin
            state_nxt    = ADDR;
            bit_cnt_nxt  = '0;
            sda_low_nxt  = 1'b0;
            selected_nxt = 1'b0;
        end else if (stop) begin
            state_nxt    = IDLE;
            sda_low_nxt  = 1'b0;
            selected_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: ;

                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = shift_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_match(shift_in, SLAVE_ADDR)) begin
                                state_nxt     = ADDR_ACK;
                                rw_nxt        = shift_in[0];
                                ack_phase_nxt = 1'b0;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_low_nxt   = 1'b1;
                            selected_nxt  = 1'b1;
                            ack_phase_nxt = 1'b1;
                        end else if (!rw) begin
                            sda_low_nxt = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = WRITE;
                        end else begin
                            tx_load_nxt = 1'b1;
                            shift_nxt   = tx_data;
                            sda_low_nxt = ~tx_data[I2C_BYTE_W-1];
                            bit_cnt_nxt = '0;
                            state_nxt   = READ;
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_nxt   = shift_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_nxt   = shift_in;
                            rx_valid_nxt  = 1'b1;
                            ack_phase_nxt = 1'b0;
                            state_nxt     = WRITE_ACK;
                        end
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_low_nxt   = 1'b1;
                            ack_phase_nxt = 1'b1;
                        end else begin
                            sda_low_nxt = 1'b0;
                            state_nxt   = WRITE;
                        end
                    end
                end

                // The bit on the bus is always shift_reg[7]; each fall advances one bit.
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_low_nxt   = 1'b0;
                            bit_cnt_nxt   = '0;
                            ack_phase_nxt = 1'b0;
                            state_nxt     = READ_ACK;
                        end else begin
                            shift_nxt   = {shift_reg[I2C_BYTE_W-2:0], 1'b0};
                            sda_low_nxt = ~shift_reg[I2C_BYTE_W-2];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end

                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_in) begin
                            selected_nxt = 1'b0;
                            state_nxt    = IDLE;
                        end else begin
                            ack_phase_nxt = 1'b1;
                        end
                    end else if (scl_fall && ack_phase) begin
                        tx_load_nxt = 1'b1;
                        shift_nxt   = tx_data;
                        sda_low_nxt = ~tx_data[I2C_BYTE_W-1];
                        state_nxt   = READ;
                    end
                end

                default: begin
                    state_nxt   = IDLE;
                    sda_low_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus-level master model drives SCL/SDA; a transaction-level
// reference predicts ACKs, received bytes, read-back bytes and tx_load counts.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       selected;
    logic       rw;

    tri1 sda_bus;
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_slave #(
        .SLAVE_ADDR (7'h42),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scl     (scl),
        .sda     (sda_bus),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_load (tx_load),
        .selected(selected),
        .rw      (rw)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] rx_q[$];
    int         tx_cnt = 0;
    int         sel_cnt = 0;
    int         slave_low_cnt = 0;
    logic [7:0] wbytes[5];
    logic [7:0] tbytes[5];
    logic       model_rw = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_load) tx_cnt++;
        if (selected) sel_cnt++;
        if (!m_low && sda_bus === 1'b0) slave_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        m_low = ~b;
        wait_q();
        scl = 1'b1;
        wait_q();
        s = sda_bus;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        tx_data = next_tx;
        bit_cycle(ack_bit, s);
    endtask

    // Reference: only address 0x42 is answered; written bytes appear on rx_data in order,
    // reads return tbytes[] (released bus = 0xFF otherwise), one tx_load per byte read.
    task automatic run_txn(input logic [6:0] a, input logic r, input int n, input string tag);
        logic       ack;
        logic       hit;
        logic [7:0] d;
        int         tx0;
        int         sel0;
        int         low0;
        hit = (a == 7'h42);
        rx_q.delete();
        tx0  = tx_cnt;
        sel0 = sel_cnt;
        low0 = slave_low_cnt;
        tx_data = tbytes[0];
        bus_start();
        write_byte({a, r}, ack);
        check({tag, ".addr_ack"}, 32'(ack), hit ? 32'd0 : 32'd1);
        check({tag, ".sel_addr"}, 32'(selected), 32'(hit));
        if (hit) model_rw = r;
        if (!r) begin
            for (int i = 0; i < n; i++) begin
                write_byte(wbytes[i], ack);
                check({tag, ".data_ack"}, 32'(ack), hit ? 32'd0 : 32'd1);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, tbytes[i+1], d);
                check({tag, ".rd_byte"}, 32'(d), hit ? 32'(tbytes[i]) : 32'hFF);
            end
            check({tag, ".sel_nack"}, 32'(selected), 32'd0);
            check({tag, ".tx_loads"}, 32'(tx_cnt - tx0), hit ? 32'(n) : 32'd0);
        end
        bus_stop();
        check({tag, ".rx_count"}, 32'(rx_q.size()), (hit && !r) ? 32'(n) : 32'd0);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check({tag, ".rx_byte"}, 32'(rx_q[i]), 32'(wbytes[i]));
        check({tag, ".sel_stop"}, 32'(selected), 32'd0);
        check({tag, ".rw"}, 32'(rw), 32'(model_rw));
        if (!hit) begin
            check({tag, ".no_drive"}, 32'(slave_low_cnt - low0), 32'd0);
            check({tag, ".no_sel"}, 32'(sel_cnt - sel0), 32'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".sda"}, 32'(sda_bus), 32'd1);
        check({tag, ".rx_data"}, 32'(rx_data), 32'd0);
        check({tag, ".rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, ".tx_load"}, 32'(tx_load), 32'd0);
        check({tag, ".selected"}, 32'(selected), 32'd0);
        check({tag, ".rw"}, 32'(rw), 32'd0);
    endtask

    task automatic recover();
        scl = 1'b1;
        m_low = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        model_rw = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] v;

        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (6) @(negedge clk);

        wbytes[0] = 8'hA5;
        run_txn(7'h42, 1'b0, 1, "t1_write");
        check("t1.rx_data", 32'(rx_data), 32'hA5);

        wbytes[0] = 8'h5E;
        run_txn(7'h43, 1'b0, 1, "t2_wrong_addr");
        check("t2.rx_data_held", 32'(rx_data), 32'hA5);

        tbytes[0] = 8'h3C;
        tbytes[1] = 8'hC3;
        tbytes[2] = 8'h00;
        run_txn(7'h42, 1'b1, 2, "t3_read");

        rx_q.delete();
        bus_start();
        write_byte(8'h84, ack);
        check("t4.addr_ack", 32'(ack), 32'd0);
        check("t4.rw_write", 32'(rw), 32'd0);
        check("t4.selected", 32'(selected), 32'd1);
        check("t4.no_rx", 32'(rx_q.size()), 32'd0);
        tbytes[0] = 8'h96;
        tbytes[1] = 8'h00;
        run_txn(7'h42, 1'b1, 1, "t4_rstart_read");

        rx_q.delete();
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h5A, ack);
        check("t5.pre_rx", 32'(rx_data), 32'h5A);
        v = 8'h3C;
        for (int i = 7; i >= 5; i--) bit_cycle(v[i], b);
        m_low = ~v[4];
        wait_q();
        scl = 1'b1;
        wait_q();
        #3 reset = 1'b0;
        #1 check_reset_vals("t5_mid_bit");
        recover();

        bus_start();
        v = 8'h84;
        for (int i = 7; i >= 0; i--) bit_cycle(v[i], b);
        m_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        check("t5.ack_driven", 32'(sda_bus), 32'd0);
        #3 reset = 1'b0;
        #1 check("t5.ack_released", 32'(sda_bus), 32'd1);
        recover();
        wbytes[0] = 8'h1F;
        run_txn(7'h42, 1'b0, 1, "t5_after_reset");

        rx_q.delete();
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h77, ack);
        v = 8'h11;
        for (int i = 7; i >= 3; i--) bit_cycle(v[i], b);
        bus_stop();
        check("t6.rx_count", 32'(rx_q.size()), 32'd1);
        check("t6.rx_data", 32'(rx_data), 32'h77);
        check("t6.selected", 32'(selected), 32'd0);

        for (int k = 0; k < 20; k++) begin
            logic [6:0] a;
            logic       r;
            int         n;
            a = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom_range(0, 127));
            r = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int i = 0; i < 5; i++) begin
                wbytes[i] = 8'($urandom);
                tbytes[i] = 8'($urandom);
            end
            run_txn(a, r, n, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
